// File: rtl/index_decoder_pkg.sv
// Shared parameters, mode encodings and radix-4 digit helpers for the index decoder.
package index_decoder_pkg;

    localparam int IDX_W  = 10;
    localparam int VEC_W  = 1024;
    localparam int STAGES = 5;

    typedef enum logic {
        MODE_ONEHOT = 1'b0,
        MODE_THERM  = 1'b1
    } mode_e;

    // A single set lane at position digit inside a 4-lane group.
    function automatic logic [3:0] onehot4(input logic [1:0] digit);
        return 4'b0001 << digit;
    endfunction

    // Lanes at or above position digit set inside a 4-lane group.
    function automatic logic [3:0] therm4(input logic [1:0] digit);
        return 4'b1111 << digit;
    endfunction

endpackage

// File: rtl/index_decoder_decode_stage.sv
// One radix-4 expansion of the decode vector (IN_W -> 4*IN_W lanes) plus its pipeline register.
module decode_stage
    import index_decoder_pkg::*;
#(
    parameter int IN_W  = 1,
    parameter int SEL_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              src_valid,
    input  logic              src_mode,
    input  logic [SEL_W-1:0]  src_index,
    input  logic [IN_W-1:0]   src_vec,
    output logic              valid_r,
    output logic              mode_r,
    output logic [SEL_W-1:0]  index_r,
    output logic [4*IN_W-1:0] vec_r
);

    logic [1:0]        digit_s;
    logic [IN_W-1:0]   below_s;
    logic [4*IN_W-1:0] expand_s;

    // The top two remaining index bits pick the lane inside each group; lower bits
    // move up so the next stage always reads its digit from the MSB end.
    assign digit_s = src_index[SEL_W-1 -: 2];
    // In thermometer form the vector is set from the boundary group upward; the
    // boundary group is the only set group whose lower neighbour is clear.
    assign below_s = src_vec << 1;

    // Expand every coarse group into four finer lanes.
    always_comb begin
        expand_s = '0;
        for (int j = 0; j < IN_W; j++) begin
            if (src_mode == MODE_THERM) begin
                if (src_vec[j] && !below_s[j]) begin
                    expand_s[4*j +: 4] = therm4(digit_s);
                end else if (src_vec[j]) begin
                    expand_s[4*j +: 4] = 4'b1111;
                end else begin
                    expand_s[4*j +: 4] = 4'b0000;
                end
            end else begin
                if (src_vec[j]) begin
                    expand_s[4*j +: 4] = onehot4(digit_s);
                end else begin
                    expand_s[4*j +: 4] = 4'b0000;
                end
            end
        end
    end

    // Stage register; a bubble loads zeros so downstream data is clean when invalid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_r <= 1'b0;
            mode_r  <= 1'b0;
            index_r <= '0;
            vec_r   <= '0;
        end else if (src_valid) begin
            valid_r <= 1'b1;
            mode_r  <= src_mode;
            index_r <= {src_index[SEL_W-3:0], 2'b00};
            vec_r   <= expand_s;
        end else begin
            valid_r <= 1'b0;
            mode_r  <= 1'b0;
            index_r <= '0;
            vec_r   <= '0;
        end
    end

endmodule

// File: rtl/index_decoder.sv
// Pipelined one-hot / thermometer index decoder built from STAGES radix-4 expansion stages.
module index_decoder #(
    parameter int IDX_W  = index_decoder_pkg::IDX_W,
    parameter int VEC_W  = index_decoder_pkg::VEC_W,
    parameter int STAGES = index_decoder_pkg::STAGES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic              in_mode,
    input  logic [IDX_W-1:0]  index,
    output logic [STAGES-1:0] debug_valid_pipe,
    output logic [VEC_W-1:0]  result,
    output logic              out_valid
);

    logic unused_tail_s;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int IN_W = 4**k;

        logic              src_valid_s;
        logic              src_mode_s;
        logic [IDX_W-1:0]  src_index_s;
        logic [IN_W-1:0]   src_vec_s;
        logic              valid_r;
        logic              mode_r;
        logic [IDX_W-1:0]  index_r;
        logic [4*IN_W-1:0] vec_r;

        // Stage 0 starts from a single set lane covering the whole output range.
        if (k == 0) begin : g_head
            assign src_valid_s = in_valid;
            assign src_mode_s  = in_mode;
            assign src_index_s = index;
            assign src_vec_s   = 1'b1;
        end else begin : g_body
            assign src_valid_s = g_stage[k-1].valid_r;
            assign src_mode_s  = g_stage[k-1].mode_r;
            assign src_index_s = g_stage[k-1].index_r;
            assign src_vec_s   = g_stage[k-1].vec_r;
        end

        decode_stage #(
            .IN_W  (IN_W),
            .SEL_W (IDX_W)
        ) u_stage (
            .clk       (clk),
            .reset     (reset),
            .src_valid (src_valid_s),
            .src_mode  (src_mode_s),
            .src_index (src_index_s),
            .src_vec   (src_vec_s),
            .valid_r   (valid_r),
            .mode_r    (mode_r),
            .index_r   (index_r),
            .vec_r     (vec_r)
        );

        assign debug_valid_pipe[k] = valid_r;
    end

    assign result    = g_stage[STAGES-1].vec_r;
    assign out_valid = g_stage[STAGES-1].valid_r;

    // The last stage's carried index and mode have no consumer.
    assign unused_tail_s = ^{g_stage[STAGES-1].mode_r, g_stage[STAGES-1].index_r};

endmodule

// File: tb/tb_index_decoder.sv
// Directed-table and scoreboard bench for index_decoder.
module tb_index_decoder;

    localparam int IDX_W  = 10;
    localparam int VEC_W  = 1024;
    localparam int STAGES = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_mode;
    logic [IDX_W-1:0]  index;
    logic [STAGES-1:0] debug_valid_pipe;
    logic [VEC_W-1:0]  result;
    logic              out_valid;

    always #5 clk = ~clk;

    index_decoder #(.IDX_W(IDX_W), .VEC_W(VEC_W), .STAGES(STAGES)) dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_mode          (in_mode),
        .index            (index),
        .debug_valid_pipe (debug_valid_pipe),
        .result           (result),
        .out_valid        (out_valid)
    );

    typedef struct {int idx; logic mode; int due;} item_t;
    typedef struct {int idx; logic mode; int exp_pop;} vec_t;

    item_t sb_q[$];
    int    cyc    = 0;
    int    n_chk  = 0;
    int    n_pass = 0;

    function automatic logic [VEC_W-1:0] model(input int idx, input logic mode);
        logic [VEC_W-1:0] seed_v;
        seed_v = mode ? {VEC_W{1'b1}} : VEC_W'(1);
        return seed_v << idx;
    endfunction

    function automatic int lowest(input logic [VEC_W-1:0] v);
        for (int i = 0; i < VEC_W; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk_int(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    task automatic chk_vec(input string name, input logic [VEC_W-1:0] act, input logic [VEC_W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got lsb=%0d pop=%0d low32=%h expected lsb=%0d pop=%0d low32=%h",
                      name, cyc, lowest(act), $countones(act), act[31:0],
                      lowest(exp), $countones(exp), exp[31:0]);
    endtask

    task automatic check_out();
        item_t it;
        if (sb_q.size() != 0 && sb_q[0].due == cyc) begin
            it = sb_q.pop_front();
            chk_int("out_valid_due", int'(out_valid), 1);
            chk_vec("result", result, model(it.idx, it.mode));
            chk_int("lowest_bit", lowest(result), it.idx);
        end else begin
            chk_int("out_valid_idle", int'(out_valid), 0);
            chk_vec("result_idle", result, '0);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        check_out();
    endtask

    task automatic issue(input int idx, input logic mode);
        in_valid = 1'b1;
        in_mode  = mode;
        index    = IDX_W'(idx);
        step();
        sb_q.push_back('{idx: idx, mode: mode, due: cyc + STAGES - 1});
        in_valid = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int exp_dbg;
        vecs[0] = '{idx: 4,    mode: 1'b1, exp_pop: 1020};
        vecs[1] = '{idx: 0,    mode: 1'b1, exp_pop: 1024};
        vecs[2] = '{idx: 1023, mode: 1'b0, exp_pop: 1};
        vecs[3] = '{idx: 1023, mode: 1'b1, exp_pop: 1};
        vecs[4] = '{idx: 0,    mode: 1'b0, exp_pop: 1};
        vecs[5] = '{idx: 512,  mode: 1'b1, exp_pop: 512};
        vecs[6] = '{idx: 3,    mode: 1'b0, exp_pop: 1};
        vecs[7] = '{idx: 700,  mode: 1'b1, exp_pop: 324};

        reset    = 1'b0;
        in_valid = 1'b0;
        in_mode  = 1'b0;
        index    = '0;
        repeat (2) step();
        chk_int("reset_debug_pipe", int'(debug_valid_pipe), 0);
        reset = 1'b1;

        // Single one-hot item walking through the pipe.
        issue(4, 1'b0);
        chk_int("pipe_stage0", int'(debug_valid_pipe), 1);
        for (int s = 1; s < STAGES; s++) begin
            step();
            exp_dbg = 1 << s;
            chk_int("pipe_walk", int'(debug_valid_pipe), exp_dbg);
        end
        chk_vec("onehot_4_const", result, VEC_W'(16));
        step();

        // Directed table.
        for (int v = 0; v < 8; v++) begin
            issue(vecs[v].idx, vecs[v].mode);
            repeat (STAGES - 1) step();
            chk_int("table_pop", $countones(result), vecs[v].exp_pop);
            chk_int("table_lsb", lowest(result), vecs[v].idx);
            step();
        end

        // Back-to-back items with alternating modes.
        issue(0, 1'b0);
        issue(1023, 1'b1);
        issue(512, 1'b0);
        issue(3, 1'b1);
        repeat (STAGES + 1) step();

        // Reset while three items are in flight.
        issue(10, 1'b0);
        issue(20, 1'b1);
        issue(30, 1'b0);
        step();
        chk_int("inflight_pipe", int'(debug_valid_pipe), 14);
        reset = 1'b0;
        sb_q.delete();
        #1;
        chk_int("rst_out_valid", int'(out_valid), 0);
        chk_vec("rst_result", result, '0);
        chk_int("rst_pipe", int'(debug_valid_pipe), 0);
        repeat (2) step();
        reset = 1'b1;
        issue(5, 1'b1);
        repeat (STAGES + 3) step();

        // Random stream with occasional bubbles.
        for (int i = 0; i < 1000; i++) begin
            issue(int'($urandom_range(0, VEC_W - 1)), logic'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) step();
        end
        repeat (STAGES + 2) step();
        chk_int("drain_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/index_decoder.md
INDEX_DECODER -- requirements
Module: index_decoder

Interface
REQ-001 SHALL have parameter IDX_W, default 10: index width in bits.
REQ-002 SHALL have parameter VEC_W, default 1024 (2**IDX_W): output vector width.
REQ-003 SHALL have parameter STAGES, default 5 (IDX_W/2): pipeline depth, one radix-4 expansion per stage.
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port clk  input  1  rising-edge clock.
REQ-006 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-007 SHALL have port in_valid  input  1  index/in_mode sampled this edge.
REQ-008 SHALL have port in_mode  input  1  0 = one-hot, 1 = thermometer.
REQ-009 SHALL have port index  input  IDX_W  bit position to decode.
REQ-010 SHALL have port debug_valid_pipe  output  STAGES  per-stage valid bits, bit 0 = stage 0.
REQ-011 SHALL have port result  output  VEC_W  decoded vector.
REQ-012 SHALL have port out_valid  output  1  result holds a decoded item.

Function
REQ-013 SHALL, in one-hot mode, produce result with only bit[index] set.
REQ-014 SHALL, in thermometer mode, produce result with bits [VEC_W-1:index] set and bits [index-1:0] clear.
REQ-015 SHALL make the lowest set bit of every valid result equal to index in both modes.
REQ-016 SHALL have a latency of exactly STAGES cycles: an item sampled at edge N appears with out_valid high after edge N+STAGES-1, i.e. during cycle N+STAGES.
REQ-017 SHALL accept one item per cycle with no backpressure, for a throughput of 1 item/clock.
REQ-018 SHALL expand the vector at each stage k by decoding index bits [2k+1:2k] from the MSB side; stage k register width is 4**(k+1).
REQ-019 SHALL carry the unused index bits and mode alongside the data in every stage.
REQ-020 SHALL propagate in_valid through a STAGES-deep valid shift register; out_valid is its last bit.
REQ-021 SHALL load zero into a stage's data register whenever that stage's incoming valid is 0, so result is all-zero whenever out_valid is 0.
REQ-022 SHALL decode each item independently when consecutive items use different modes; there is no cross-item state.
REQ-023 SHALL produce result bit[0] only for index 0 in one-hot mode, and all VEC_W bits set for index 0 in thermometer mode.
REQ-024 SHALL produce result with only bit[VEC_W-1] set for index VEC_W-1, in both modes.

Reset
REQ-025 SHALL, while reset is low, immediately clear all valid bits, all data registers, result (0) and out_valid (0).
REQ-026 SHALL discard any items in flight when reset asserts mid-operation; none are emitted after release.
REQ-027 SHALL, in the first cycle after reset deasserts, sample in_valid normally.

Structure
REQ-028 SHALL place IDX_W, VEC_W, STAGES and the mode encodings (MODE_ONEHOT=0, MODE_THERM=1) in the shared package.
REQ-029 SHALL use one sub-module, decode_stage, parameterized by input width, which performs one radix-4 expansion plus register.
REQ-030 SHALL instantiate decode_stage STAGES times via generate.

Verification
REQ-031 SHALL cover: reset 2 cycles, index=4, mode 0, in_valid for 1 cycle -> out_valid 5 cycles later for 1 cycle, result = 1<<4.
REQ-032 SHALL cover: index=4, mode 1 -> result bits [1023:4] set, [3:0] clear; the lowest set bit is 4.
REQ-033 SHALL cover: back-to-back index 0,1023,512,3 with alternating modes -> four consecutive out_valid cycles with the correct vectors, in order.
REQ-034 SHALL cover: index 0 mode 1 -> all ones; index 1023 mode 0 -> only bit 1023 set.
REQ-035 SHALL cover: 3 items issued, reset pulled low 2 cycles later -> out_valid and result 0 immediately, no item emitted after release.
REQ-036 SHALL cover: random 1000 indices and modes -> the lowest set bit of each result equals index and the scoreboard matches.
